addsub_scheduler: RTL and testbench

ADDSUB_SCHEDULER -- requirements
Module: addsub_scheduler

---
 rtl/addsub_pkg.sv | 12 +
 rtl/addsub_scheduler_rr_arbiter.sv | 31 +++
 rtl/addsub_scheduler.sv | 105 ++++++++++
 tb/tb_addsub_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract scheduler: datapath width and FSM states.
package addsub_pkg;

  localparam int ADDSUB_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_scheduler_rr_arbiter.sv
// Round-robin selector: scans requesters starting at ptr and grants the first valid one.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  int   cand;
  logic hit;

  // Candidates are visited in rotated order, so the first hit is the fairest winner.
  always_comb begin
    grant = '0;
    index = '0;
    hit   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!hit && valid[cand]) begin
        hit         = 1'b1;
        grant[cand] = 1'b1;
        index       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/addsub_scheduler.sv
// Time-shares one external 64-bit adder between NREQ requesters, one operation at a time.
module addsub_scheduler
  import addsub_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int WIDTH   = ADDSUB_W,
  parameter int ADD_LAT = 1,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic [WIDTH-1:0]      add_op1,
  output logic [WIDTH-1:0]      add_op2,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
);

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr, win_idx, ptr_next;
  logic [NREQ-1:0] grant;
  logic [2:0]      lat_cnt;
  logic            accept, last_exec;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic            sel_sub;

  rr_arbiter #(
    .N  (NREQ),
    .IW (ID_W)
  ) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .index (win_idx)
  );

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? grant : '0;
  assign last_exec = (state == EXEC) && (lat_cnt == 3'(ADD_LAT - 1));
  assign sel_a     = req_a[win_idx*WIDTH +: WIDTH];
  assign sel_b     = req_b[win_idx*WIDTH +: WIDTH];
  assign sel_sub   = req_sub[win_idx];
  assign ptr_next  = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = EXEC;
      EXEC:    if (last_exec) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the inverted operand and carry-in are latched at grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      lat_cnt   <= '0;
      add_op1   <= '0;
      add_op2   <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        add_op1 <= sel_a;
        add_op2 <= sel_sub ? ~sel_b : sel_b;
        add_cin <= sel_sub;
        rsp_id  <= win_idx;
        rr_ptr  <= ptr_next;
        lat_cnt <= '0;
      end
      if (state == EXEC) lat_cnt <= lat_cnt + 3'd1;
      if (last_exec) begin
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_ovf   <= (add_op1[WIDTH-1] == add_op2[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != add_op1[WIDTH-1]);
        rsp_valid <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_scheduler.sv
// Randomised self-checking bench for addsub_scheduler against an arithmetic reference model.
module tb_addsub_scheduler;

  localparam int NREQ    = 3;
  localparam int WIDTH   = 64;
  localparam int ADD_LAT = 2;
  localparam int ID_W    = 2;
  localparam logic signed [65:0] SMAX = 66'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -66'sh8000_0000_0000_0000;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_sub = '0;
  logic [WIDTH-1:0]      add_op1, add_op2, add_sum;
  logic                  add_cin, add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout, rsp_ovf;

  int checks = 0;
  int passes = 0;
  int model_ptr = 0;

  logic [NREQ-1:0]  obs_ready, obs_busy, exp_grant;
  logic [WIDTH-1:0] obs_op1, obs_op2, obs_sum;
  logic             obs_cin, obs_cout, obs_ovf, obs_after;
  logic [ID_W-1:0]  obs_id;
  int               obs_lat, obs_unstable, exp_id;
  logic [WIDTH-1:0] exp_a, exp_b, exp_sum;
  logic             exp_sub, exp_cout, exp_ovf;

  addsub_scheduler #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .add_op1   (add_op1),
    .add_op2   (add_op2),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clock = ~clock;

  // External adder with ADD_LAT-1 register stages, so an early capture sees a stale sum.
  logic [WIDTH:0] adder_q;
  always @(posedge clock)
    adder_q <= {1'b0, add_op1} + {1'b0, add_op2} + {{WIDTH{1'b0}}, add_cin};
  assign add_sum  = adder_q[WIDTH-1:0];
  assign add_cout = adder_q[WIDTH];

  function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                output logic [63:0] s, output logic c, output logic v);
    logic [64:0] wide;
    logic signed [65:0] sr;
    if (sub) begin
      s = a - b;
      c = (a >= b);
      sr = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s = wide[63:0];
      c = wide[64];
      sr = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    end
    v = (sr > SMAX) || (sr < SMIN);
  endfunction

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic sub);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_sub[i] = sub;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_ptr = 0;
  endtask

  // Drives one request from the IDLE state through to its response; records observations.
  task automatic do_op(input logic [NREQ-1:0] mask, input bit keep, input int hold);
    req_valid = mask;
    #1 obs_ready = req_ready;
    exp_id = pick(mask, model_ptr);
    model_ptr = (exp_id + 1) % NREQ;
    exp_grant = NREQ'(1) << exp_id;
    exp_a = req_a[exp_id*WIDTH +: WIDTH];
    exp_b = req_b[exp_id*WIDTH +: WIDTH];
    exp_sub = req_sub[exp_id];
    model(exp_a, exp_b, exp_sub, exp_sum, exp_cout, exp_ovf);
    @(posedge clock); #1;
    obs_busy = req_ready;
    obs_op1 = add_op1;
    obs_op2 = add_op2;
    obs_cin = add_cin;
    if (!keep) req_valid = '0;
    obs_lat = 1;
    obs_unstable = 0;
    while (!rsp_valid && obs_lat < 20) begin
      @(posedge clock); #1;
      obs_lat++;
      if (!rsp_valid && {add_op1, add_op2, add_cin} !== {obs_op1, obs_op2, obs_cin})
        obs_unstable++;
    end
    obs_id = rsp_id;
    obs_sum = rsp_sum;
    obs_cout = rsp_cout;
    obs_ovf = rsp_ovf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {obs_id, obs_sum, obs_cout, obs_ovf}
          || req_ready !== '0)
        obs_unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    obs_after = rsp_valid;
  endtask

  task automatic test_reset();
    set_req(0, 64'h1234, 64'h5678, 1'b1);
    reset = 1'b1;
    req_valid = '1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    req_valid = '0;
    model_ptr = 0;
    #1;
    checks++; if ({rsp_valid, add_cin, rsp_cout, rsp_ovf} !== 4'b0)
      $display("[TB] FAIL reset_flags: got %b expected 0000", {rsp_valid, add_cin, rsp_cout, rsp_ovf}); else passes++;
    checks++; if (add_op1 !== '0) $display("[TB] FAIL reset_op1: got %h expected 0", add_op1); else passes++;
    checks++; if (add_op2 !== '0) $display("[TB] FAIL reset_op2: got %h expected 0", add_op2); else passes++;
    checks++; if (rsp_sum !== '0) $display("[TB] FAIL reset_sum: got %h expected 0", rsp_sum); else passes++;
    checks++; if (rsp_id !== '0) $display("[TB] FAIL reset_id: got %0d expected 0", rsp_id); else passes++;
    checks++; if (req_ready !== '0) $display("[TB] FAIL reset_ready: got %b expected 000", req_ready); else passes++;
  endtask

  task automatic test_directed();
    logic [63:0] ta [5] = '{64'd5, 64'd3, 64'd5, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    logic [63:0] tb [5] = '{64'd7, 64'd5, 64'd3, 64'd1, 64'd1};
    logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      set_req(0, ta[i], tb[i], ts[i]);
      do_op(3'b001, 1'b0, 0);
      checks++; if (obs_ready !== 3'b001) $display("[TB] FAIL dir_grant[%0d]: got %b expected 001", i, obs_ready); else passes++;
      checks++; if ({obs_op1, obs_op2, obs_cin} !== {ta[i], ts[i] ? ~tb[i] : tb[i], ts[i]})
        $display("[TB] FAIL dir_operands[%0d]: got %h %h %b", i, obs_op1, obs_op2, obs_cin); else passes++;
      checks++; if (obs_lat !== ADD_LAT + 1) $display("[TB] FAIL dir_latency[%0d]: got %0d expected %0d", i, obs_lat, ADD_LAT + 1); else passes++;
      checks++; if ({obs_id, obs_sum, obs_cout, obs_ovf} !== {2'd0, exp_sum, exp_cout, exp_ovf})
        $display("[TB] FAIL dir_result[%0d]: got id=%0d sum=%h c=%b v=%b expected sum=%h c=%b v=%b",
                 i, obs_id, obs_sum, obs_cout, obs_ovf, exp_sum, exp_cout, exp_ovf); else passes++;
    end
    checks++; if (exp_sum !== 64'h7FFF_FFFF_FFFF_FFFF || obs_ovf !== 1'b1)
      $display("[TB] FAIL dir_min_minus_one: got sum=%h ovf=%b expected 7fffffffffffffff 1", obs_sum, obs_ovf); else passes++;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} >> $urandom_range(0, 63)
                : {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_op(mask, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      checks++; if (obs_ready !== exp_grant) $display("[TB] FAIL rnd_grant[%0d]: got %b expected %b", n, obs_ready, exp_grant); else passes++;
      checks++; if (obs_busy !== '0) $display("[TB] FAIL rnd_busy_ready[%0d]: got %b expected 000", n, obs_busy); else passes++;
      checks++; if (obs_lat !== ADD_LAT + 1 || obs_unstable !== 0)
        $display("[TB] FAIL rnd_timing[%0d]: got lat=%0d unstable=%0d expected %0d 0", n, obs_lat, obs_unstable, ADD_LAT + 1); else passes++;
      checks++; if ({obs_id, obs_sum, obs_cout, obs_ovf} !== {ID_W'(exp_id), exp_sum, exp_cout, exp_ovf})
        $display("[TB] FAIL rnd_result[%0d]: got id=%0d sum=%h c=%b v=%b expected id=%0d sum=%h c=%b v=%b",
                 n, obs_id, obs_sum, obs_cout, obs_ovf, exp_id, exp_sum, exp_cout, exp_ovf); else passes++;
    end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    set_req(0, 64'd100, 64'd1, 1'b0);
    set_req(1, 64'd100, 64'd1, 1'b1);
    for (int n = 0; n < 8; n++) begin
      do_op(3'b011, 1'b1, 0);
      checks++; if (obs_id !== ID_W'(n % 2)) $display("[TB] FAIL fair_id[%0d]: got %0d expected %0d", n, obs_id, n % 2); else passes++;
      checks++; if (obs_sum !== ((n % 2 == 0) ? 64'd101 : 64'd99))
        $display("[TB] FAIL fair_sum[%0d]: got %0d expected %0d", n, obs_sum, (n % 2 == 0) ? 101 : 99); else passes++;
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back_backpressure();
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    set_req(1, 64'd9, 64'd4, 1'b1);
    do_op(3'b011, 1'b1, 5);
    checks++; if (obs_unstable !== 0) $display("[TB] FAIL bp_stable: got %0d glitches expected 0", obs_unstable); else passes++;
    checks++; if (obs_busy !== '0) $display("[TB] FAIL bp_busy_ready: got %b expected 000", obs_busy); else passes++;
    checks++; if (obs_after !== 1'b0) $display("[TB] FAIL bp_single_rsp: got rsp_valid=%b expected 0", obs_after); else passes++;
    checks++; if ({obs_id, obs_sum, obs_cout, obs_ovf} !== {ID_W'(exp_id), exp_sum, exp_cout, exp_ovf})
      $display("[TB] FAIL bp_result: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%b", obs_id, obs_sum, obs_cout, exp_id, exp_sum, exp_cout); else passes++;
    req_valid = '0;
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    set_req(0, 64'd1, 64'd2, 1'b0);
    set_req(1, 64'd40, 64'd2, 1'b0);
    req_valid = 3'b001;
    @(posedge clock); #1;
    req_valid = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_ptr = 0;
    checks++; if ({rsp_valid, add_op1, add_op2, add_cin, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== '0)
      $display("[TB] FAIL rst_exec_clear: got op1=%h op2=%h valid=%b", add_op1, add_op2, rsp_valid); else passes++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) $display("[TB] FAIL rst_exec_no_rsp: got %0d responses expected 0", seen); else passes++;
    do_op(3'b011, 1'b0, 0);
    checks++; if (obs_id !== '0 || obs_sum !== 64'd3)
      $display("[TB] FAIL rst_exec_next: got id=%0d sum=%0d expected id=0 sum=3", obs_id, obs_sum); else passes++;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_fairness();
    test_back_to_back_backpressure();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
